// File: rtl/serial_subtractor_ctrl_if.sv
// Purpose: host <-> bit-serial subtractor controller bundle (start/busy/done + operands/result).
// Latency: n/a (signal bundle only).
// Backpressure: none; start is only honoured while the controller is idle.
// Ports: master = host (drives start/a/b/bin), slave = controller (drives busy/done/diff/borrow_out).
interface serial_subtractor_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, borrow_out
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, borrow_out
    );
endinterface

// File: rtl/serial_subtractor_ctrl.sv
// Purpose: bit-serial a - b - bin using one 1-bit full-subtractor cell, LSB first.
// Latency: done pulses WIDTH edges after the accepting start edge; one op per WIDTH+2 cycles.
// Backpressure: start is sampled only in IDLE; requests while busy/done are dropped, not queued.
// Ports: clock (rising edge), reset_n (async active-low), bus (slave modport):
//        start/a/b/bin in, busy/done/diff/borrow_out out (all outputs registered).
module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                    clock,
    input  logic                    reset_n,
    serial_subtractor_ctrl_if.slave bus
);
    localparam int CW = (WIDTH <= 2) ? 1 : $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             brw;
    logic [CW-1:0]    cnt;

    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;

    // Shared 1-bit full-subtractor cell on the current LSBs and the held borrow.
    logic             x;
    logic             y;
    logic             z;
    logic             d_bit;
    logic             b_bit;
    logic [WIDTH-1:0] res_next;

    assign x        = a_sh[0];
    assign y        = b_sh[0];
    assign z        = brw;
    assign d_bit    = x ^ y ^ z;
    assign b_bit    = (~x & y) | (~x & z) | (y & z);
    // Result bits enter at the MSB so after WIDTH shifts bit 0 lands at diff[0].
    assign res_next = {d_bit, res_sh[WIDTH-1:1]};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            brw      <= 1'b0;
            cnt      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_sh   <= bus.a;
                        b_sh   <= bus.b;
                        brw    <= bus.bin;
                        cnt    <= '0;
                        res_sh <= '0;
                        busy_q <= 1'b1;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    res_sh <= res_next;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    brw    <= b_bit;
                    if (cnt == LAST) begin
                        // Final bit: publish the whole result at once so diff never
                        // shows a partially shifted value. cnt stays at WIDTH-1.
                        diff_q   <= res_next;
                        borrow_q <= b_bit;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;
endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Purpose: self-checking bench for serial_subtractor_ctrl with a result scoreboard.
// Latency: expects done WIDTH edges after the accepting start edge, next accept at WIDTH+2.
// Backpressure: checks that start is ignored while busy/done and that reset aborts cleanly.
module tb_serial_subtractor_ctrl;
    localparam int W = 8;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    serial_subtractor_ctrl_if #(.WIDTH(W)) bus ();

    serial_subtractor_ctrl #(.WIDTH(W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_done = 0;
    logic [W:0] sb_q[$];   // {borrow_out, diff}

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic bin);
        logic [W:0] r;
        r[W-1:0] = a - b - {{(W-1){1'b0}}, bin};
        r[W]     = ({1'b0, a} < ({1'b0, b} + {{W{1'b0}}, bin}));
        return r;
    endfunction

    // Scoreboard consumer: every done pulse pops one expected result.
    always @(posedge clock) begin
        logic [W:0] e;
        #1;
        if (reset_n && bus.done) begin
            n_done++;
            if (sb_q.size() == 0) begin
                chk_eq("unexpected_done", 32'(bus.done), 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk_eq("diff", 32'(bus.diff), 32'(e[W-1:0]));
                chk_eq("borrow_out", 32'(bus.borrow_out), 32'(e[W]));
            end
        end
    end

    task automatic wait_done();
        int i;
        for (i = 0; i < 4 * W; i++) begin
            @(posedge clock);
            #1;
            if (bus.done) break;
        end
        if (i == 4 * W) chk_eq("done_timeout", 32'(bus.done), 32'd1);
    endtask

    // Issue one op, wait for done, then one more edge so the FSM is back in IDLE.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         input logic [W:0] exp);
        @(negedge clock);
        bus.a     = a;
        bus.b     = b;
        bus.bin   = bin;
        bus.start = 1'b1;
        sb_q.push_back(exp);
        @(negedge clock);
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.bin   = 1'($urandom);
        wait_done();
        @(posedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] d_tt;
        logic [7:0] b_tt;
        logic [W:0] r1;
        logic       xb, yb, zb, dd, bb;
        int         edges, busy_cycles;

        d_tt = 8'b1001_0110;
        b_tt = 8'b1000_1110;

        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk_eq("rst_busy", 32'(bus.busy), 32'd0);
        chk_eq("rst_done", 32'(bus.done), 32'd0);
        chk_eq("rst_diff", 32'(bus.diff), 32'd0);
        chk_eq("rst_borrow", 32'(bus.borrow_out), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // 1: 100 - 37 with latency / busy-length checks.
        @(negedge clock);
        bus.a     = 8'd100;
        bus.b     = 8'd37;
        bus.bin   = 1'b0;
        bus.start = 1'b1;
        sb_q.push_back({1'b0, 8'd63});
        @(posedge clock);
        #1;
        chk_eq("t1_busy_after_accept", 32'(bus.busy), 32'd1);
        @(negedge clock);
        bus.start = 1'b0;
        edges       = 0;
        busy_cycles = 1;
        for (int i = 0; i < 4 * W; i++) begin
            @(posedge clock);
            #1;
            edges++;
            if (bus.done) break;
            if (bus.busy) busy_cycles++;
        end
        chk_eq("t1_edges_to_done", 32'(edges), 32'(W));
        chk_eq("t1_busy_cycles", 32'(busy_cycles), 32'(W));
        chk_eq("t1_busy_in_done", 32'(bus.busy), 32'd0);
        @(posedge clock);
        #1;
        chk_eq("t1_done_one_cycle", 32'(bus.done), 32'd0);
        chk_eq("t1_diff_held_idle", 32'(bus.diff), 32'd63);

        // 2, 3: borrow corner cases.
        do_op(8'd5,   8'd10,  1'b0, {1'b1, 8'd251});
        do_op(8'd0,   8'd0,   1'b1, {1'b1, 8'd255});
        do_op(8'd255, 8'd255, 1'b1, {1'b1, 8'd255});
        do_op(8'd128, 8'd1,   1'b1, {1'b0, 8'd126});

        // 5: reset in the 4th RUN cycle aborts without a done pulse.
        @(negedge clock);
        bus.a     = 8'd200;
        bus.b     = 8'd50;
        bus.bin   = 1'b0;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk_eq("t5_busy", 32'(bus.busy), 32'd0);
        chk_eq("t5_done", 32'(bus.done), 32'd0);
        chk_eq("t5_diff", 32'(bus.diff), 32'd0);
        chk_eq("t5_borrow", 32'(bus.borrow_out), 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        do_op(8'd200, 8'd50, 1'b0, {1'b0, 8'd150});

        // 4: start held high, operands scrambled every cycle.
        r1 = '0;
        for (int k = 0; k <= 2 * W + 2; k++) begin
            @(negedge clock);
            bus.a     = W'($urandom);
            bus.b     = W'($urandom);
            bus.bin   = 1'($urandom);
            bus.start = 1'b1;
            if (k == 0 || k == W + 2) sb_q.push_back(ref_sub(bus.a, bus.b, bus.bin));
            if (k == 0) r1 = ref_sub(bus.a, bus.b, bus.bin);
            @(posedge clock);
            #1;
            if (k == 0)     chk_eq("t4_first_accept", 32'(bus.busy), 32'd1);
            if (k == W)     chk_eq("t4_first_done", 32'(bus.done), 32'd1);
            if (k == W + 1) chk_eq("t4_idle_gap", 32'(bus.busy), 32'd0);
            if (k == W + 2) chk_eq("t4_second_accept", 32'(bus.busy), 32'd1);
            if (k >= W + 2 && k <= 2 * W + 1)
                chk_eq("t4_diff_hold", 32'(bus.diff), 32'(r1[W-1:0]));
        end
        @(negedge clock);
        bus.start = 1'b0;
        @(posedge clock);

        // 6: full bit-cell truth table through the LSB.
        for (int i = 0; i < 8; i++) begin
            xb = 1'((i >> 2) & 1);
            yb = 1'((i >> 1) & 1);
            zb = 1'(i & 1);
            dd = d_tt[i];
            bb = b_tt[i];
            do_op({7'b0, xb}, {7'b0, yb}, zb, {bb, (bb ? 7'h7f : 7'h00), dd});
        end

        repeat (2) @(posedge clock);
        chk_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        chk_eq("done_count", 32'(n_done), 32'd16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
